if_fetch_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 22 ++
 rtl/if_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mips_pkg;

    localparam int                 INSTR_W   = 32;
    localparam logic [31:0]        PC_INC    = 32'd4;
    // MIPS "sll $0,$0,0"
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    // Force a fetch target onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding imem request, feeds IF/ID.
// Latency: captured word appears on instruction/pc_plus4/valid one edge after imem_ready.
// Backpressure: stall freezes outputs; a word returning under stall parks in a 1-entry skid.
//
// Ports: clock/reset (async, active-high); stall, redirect, redirect_pc from decode/execute;
// imem_req/imem_addr/imem_ready/imem_rdata to instruction memory;
// instruction/pc_plus4/valid to the IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count and stall_count outputs.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0]        RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic [31:0]        pc_plus4,
    output logic               valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        stall_count
`endif
);

    fetch_state_e       state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        pc4_q, pc4_d;
    logic               valid_q, valid_d;
    logic               kill_q, kill_d;
    logic [31:0]        target_q, target_d;
    logic               skid_vld_q, skid_vld_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [31:0]        skid_pc4_q, skid_pc4_d;
    logic [31:0]        pc_inc;
    logic               capture;

    assign pc_inc  = fetch_pc_q + PC_INC;
    // A live word accepted from memory; killed or redirected returns do not count.
    assign capture = (state_q == REQ) && imem_ready && !kill_q && !redirect;

    // State resets to IDLE asynchronously, so the request drops with reset.
    assign imem_req    = (state_q == REQ);
    assign imem_addr   = fetch_pc_q;
    assign instruction = instr_q;
    assign pc_plus4    = pc4_q;
    assign valid       = valid_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        kill_d       = kill_q;
        target_d     = target_q;
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        if (redirect) begin
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
            skid_vld_d = 1'b0;
            if ((state_q == REQ) && !imem_ready) begin
                // Address must stay stable until the pending word returns;
                // remember where to go and drop that word when it lands.
                kill_d   = 1'b1;
                target_d = word_align(redirect_pc);
            end else begin
                kill_d     = 1'b0;
                fetch_pc_d = word_align(redirect_pc);
                state_d    = REQ;
            end
        end else begin
            // Downstream consumed the current word; without a new one, go invalid.
            if (!stall) begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_ready && kill_q) begin
                        kill_d     = 1'b0;
                        fetch_pc_d = target_q;
                    end else if (capture) begin
                        fetch_pc_d = pc_inc;
                        if (stall) begin
                            skid_vld_d   = 1'b1;
                            skid_instr_d = imem_rdata;
                            skid_pc4_d   = pc_inc;
                            state_d      = HOLD;
                        end else begin
                            instr_d = imem_rdata;
                            pc4_d   = pc_inc;
                            valid_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_d    = skid_instr_q;
                        pc4_d      = skid_pc4_q;
                        valid_d    = skid_vld_q;
                        skid_vld_d = 1'b0;
                        state_d    = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
            kill_q       <= 1'b0;
            target_q     <= '0;
            skid_vld_q   <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            kill_q       <= kill_d;
            target_q     <= target_d;
            skid_vld_q   <= skid_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (capture)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall && valid_q)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, zero-wait streaming, wait states,
// stall/skid, redirects, PC wrap, async reset mid-request, optional perf counters.
// Memory model returns the request address as the instruction word.
module tb_if_fetch_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        mem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        valid;

    // Second instance with a reset PC at the top of the address space.
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;
    logic        w_valid;
    logic        w_one;
    logic        w_zero;
    logic [31:0] w_zero32;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
    logic [31:0] w_fc, w_sc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    assign imem_rdata = imem_addr;
    assign w_rdata    = w_addr;
    assign w_one      = 1'b1;
    assign w_zero     = 1'b0;
    assign w_zero32   = 32'h0;

    if_fetch_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(mem_ready), .imem_rdata(imem_rdata), .instruction(instruction),
        .pc_plus4(pc_plus4), .valid(valid)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clock(clock), .reset(reset), .stall(w_zero), .redirect(w_zero),
        .redirect_pc(w_zero32), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(w_one), .imem_rdata(w_rdata), .instruction(w_instr),
        .pc_plus4(w_pc4), .valid(w_valid)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(w_fc), .stall_count(w_sc)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves both DUTs in REQ (one edge after release), nothing captured yet.
    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_ready = 1'b1;
        step(); step();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid); end
        n_checks++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", instruction); end
        n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL rst_pc4: got %h want 0", pc_plus4); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        n_checks++; if (w_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rst_w_addr: got %h want fffffffc", w_addr); end
        n_checks++; if (w_req !== 1'b0) begin n_fail++; $display("FAIL rst_w_req: got %b want 0", w_req); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL zw_first_req: req=%b addr=%h valid=%b want 1/0/0", imem_req, imem_addr, valid);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++; if (valid !== 1'b1 || instruction !== 32'(4*k) || pc_plus4 !== 32'(4*k+4) || imem_addr !== 32'(4*k+4)) begin
                n_fail++;
                $display("FAIL zw_stream[%0d]: valid=%b instr=%h pc4=%h addr=%h want 1/%h/%h/%h",
                         k, valid, instruction, pc_plus4, imem_addr, 32'(4*k), 32'(4*k+4), 32'(4*k+4));
            end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        step(); step();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1 || valid !== 1'b0) begin
                n_fail++; $display("FAIL ws_hold[%0d]: addr=%h req=%b valid=%b want 8/1/0", i, imem_addr, imem_req, valid);
            end
        end
        mem_ready = 1'b1;
        step();
        n_checks++; if (valid !== 1'b1 || instruction !== 32'h8 || pc_plus4 !== 32'hC || imem_addr !== 32'hC) begin
            n_fail++; $display("FAIL ws_capture: valid=%b instr=%h pc4=%h addr=%h want 1/8/c/c", valid, instruction, pc_plus4, imem_addr);
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 5; i++) step();
        n_checks++; if (instruction !== 32'h10 || pc_plus4 !== 32'h14) begin
            n_fail++; $display("FAIL st_pre: instr=%h pc4=%h want 10/14", instruction, pc_plus4);
        end
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (valid !== 1'b1 || instruction !== 32'h10 || pc_plus4 !== 32'h14) begin
                n_fail++; $display("FAIL st_frozen[%0d]: valid=%b instr=%h pc4=%h want 1/10/14", i, valid, instruction, pc_plus4);
            end
        end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_hold_req: got %b want 0", imem_req); end
        stall = 1'b0;
        step();
        n_checks++; if (valid !== 1'b1 || instruction !== 32'h14 || pc_plus4 !== 32'h18) begin
            n_fail++; $display("FAIL st_skid_out: valid=%b instr=%h pc4=%h want 1/14/18", valid, instruction, pc_plus4);
        end
        step();
        n_checks++; if (valid !== 1'b1 || instruction !== 32'h18 || pc_plus4 !== 32'h1C) begin
            n_fail++; $display("FAIL st_resume: valid=%b instr=%h pc4=%h want 1/18/1c", valid, instruction, pc_plus4);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 8; i++) step();
        n_checks++; if (imem_addr !== 32'h20 || instruction !== 32'h1C) begin
            n_fail++; $display("FAIL rd_pre: addr=%h instr=%h want 20/1c", imem_addr, instruction);
        end
        mem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h403;
        step();
        redirect = 1'b0;
        n_checks++; if (imem_addr !== 32'h20 || valid !== 1'b0 || instruction !== 32'h0) begin
            n_fail++; $display("FAIL rd_kill: addr=%h valid=%b instr=%h want 20/0/0", imem_addr, valid, instruction);
        end
        step();
        n_checks++; if (imem_addr !== 32'h20 || imem_req !== 1'b1 || valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_wait: addr=%h req=%b valid=%b want 20/1/0", imem_addr, imem_req, valid);
        end
        mem_ready = 1'b1;
        step();
        n_checks++; if (imem_addr !== 32'h400 || valid !== 1'b0 || instruction !== 32'h0) begin
            n_fail++; $display("FAIL rd_drop: addr=%h valid=%b instr=%h want 400/0/0", imem_addr, valid, instruction);
        end
        step();
        n_checks++; if (valid !== 1'b1 || instruction !== 32'h400 || pc_plus4 !== 32'h404) begin
            n_fail++; $display("FAIL rd_target: valid=%b instr=%h pc4=%h want 1/400/404", valid, instruction, pc_plus4);
        end
    endtask

    task automatic test_back_to_back();
        // Second redirect while a kill is pending overwrites the target.
        do_reset();
        step();
        mem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_pc = 32'h205;
        step();
        n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL bb_addr_stable: got %h want 4", imem_addr); end
        redirect = 1'b0; mem_ready = 1'b1;
        step();
        n_checks++; if (imem_addr !== 32'h204 || valid !== 1'b0) begin
            n_fail++; $display("FAIL bb_overwrite: addr=%h valid=%b want 204/0", imem_addr, valid);
        end
        step();
        n_checks++; if (valid !== 1'b1 || instruction !== 32'h204) begin
            n_fail++; $display("FAIL bb_fetch: valid=%b instr=%h want 1/204", valid, instruction);
        end
        // Redirect coincident with ready: returned word is dropped, target used next.
        do_reset();
        step();
        redirect = 1'b1; redirect_pc = 32'h50;
        step();
        redirect = 1'b0;
        n_checks++; if (imem_addr !== 32'h50 || valid !== 1'b0) begin
            n_fail++; $display("FAIL bb_coincide: addr=%h valid=%b want 50/0", imem_addr, valid);
        end
        step();
        n_checks++; if (valid !== 1'b1 || instruction !== 32'h50 || pc_plus4 !== 32'h54) begin
            n_fail++; $display("FAIL bb_coincide_fetch: valid=%b instr=%h pc4=%h want 1/50/54", valid, instruction, pc_plus4);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        n_checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wr_first: req=%b addr=%h want 1/fffffffc", w_req, w_addr);
        end
        step();
        n_checks++; if (w_valid !== 1'b1 || w_instr !== 32'hFFFF_FFFC || w_pc4 !== 32'h0 || w_addr !== 32'h0) begin
            n_fail++; $display("FAIL wr_edge: valid=%b instr=%h pc4=%h addr=%h want 1/fffffffc/0/0", w_valid, w_instr, w_pc4, w_addr);
        end
        step();
        n_checks++; if (w_instr !== 32'h0 || w_pc4 !== 32'h4) begin
            n_fail++; $display("FAIL wr_next: instr=%h pc4=%h want 0/4", w_instr, w_pc4);
        end
    endtask

    task automatic test_reset_mid_request();
        do_reset();
        mem_ready = 1'b0;
        step();
        #3;
        reset = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset: req=%b addr=%h want 0/0", imem_req, imem_addr);
        end
        step();
        reset = 1'b0;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        n_checks++; if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
            n_fail++; $display("FAIL perf_reset: fetch=%0d stall=%0d want 0/0", fetch_count, stall_count);
        end
        for (int i = 0; i < 10; i++) step();
        mem_ready = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect = 1'b0; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        n_checks++; if (fetch_count !== 32'd10 || stall_count !== 32'd3) begin
            n_fail++; $display("FAIL perf_counts: fetch=%0d stall=%0d want 10/3", fetch_count, stall_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_ready = 1'b1;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid_request();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
